// File: rtl/host_mem_xfer_ctrl_pkg.sv
// Shared types for the host-port transfer engine: FSM encodings and command direction codes.
// WORD_LEN normally comes from the kernel defines; a 32-bit fallback keeps this slice self-contained.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package host_mem_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    XFER_IDLE  = 2'd0,
    XFER_WRITE = 2'd1,
    XFER_READ  = 2'd2,
    XFER_DONE  = 2'd3
  } xfer_state_e;

  localparam logic XFER_DIR_WR = 1'b0;
  localparam logic XFER_DIR_RD = 1'b1;

endpackage

// File: rtl/host_mem_xfer_ctrl_rd_outreg.sv
// One-entry read output register: loads a memory word, holds it stable under backpressure,
// and drops valid once the held word is consumed without a replacement.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module xfer_rd_outreg #(
  parameter int W = `WORD_LEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         last_in,
  input  logic [W-1:0] din,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         rd_last
);

  // Output word register with valid/ready hold behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= {W{1'b0}};
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (load) begin
      rd_data  <= din;
      rd_valid <= 1'b1;
      rd_last  <= last_in;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/host_mem_xfer_ctrl.sv
// Host-side transfer engine driving data-memory port B: streams a {dir, base, len} command
// in or out with valid/ready handshakes. Optional running checksum output: HOST_MEM_CHKSUM_EN.
module host_mem_xfer_ctrl
  import host_mem_xfer_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_dir,
  input  logic [ADDR_W-1:0]    i_cmd_base,
  input  logic [LEN_W-1:0]     i_cmd_len,
  input  logic [`WORD_LEN-1:0] i_wr_data,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  output logic [`WORD_LEN-1:0] o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic                 o_rd_last,
  output logic                 o_host_mem_wr_en,
  output logic                 o_host_mem_rd_en,
  output logic [ADDR_W-1:0]    o_host_addr,
  output logic [`WORD_LEN-1:0] o_host_din,
  input  logic [`WORD_LEN-1:0] i_host_dout,
  output logic                 o_busy,
  output logic                 o_done
`ifdef HOST_MEM_CHKSUM_EN
  ,
  output logic [`WORD_LEN-1:0] o_chksum
`endif
);

  xfer_state_e       state_r, state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  rem_r;
  logic              done_r;
  logic              accept_s, wr_hs_s, load_s, rd_hs_s, rem_nz_s, last_s;

  assign rem_nz_s    = (rem_r != {LEN_W{1'b0}});
  assign last_s      = (rem_r == LEN_W'(1));
  assign rd_hs_s     = o_rd_valid && i_rd_ready;
  assign o_host_addr = addr_r;
  assign o_host_din  = i_wr_data;
  assign o_busy      = (state_r != XFER_IDLE);
  assign o_done      = done_r;

  // Next-state and per-state port-B / handshake strobes.
  always_comb begin
    state_s          = state_r;
    o_cmd_ready      = 1'b0;
    o_wr_ready       = 1'b0;
    o_host_mem_wr_en = 1'b0;
    o_host_mem_rd_en = 1'b0;
    accept_s         = 1'b0;
    wr_hs_s          = 1'b0;
    load_s           = 1'b0;
    case (state_r)
      XFER_IDLE: begin
        o_cmd_ready = 1'b1;
        accept_s    = i_cmd_valid;
        if (!i_cmd_valid) begin
          state_s = XFER_IDLE;
        end else if (i_cmd_len == {LEN_W{1'b0}}) begin
          state_s = XFER_DONE;
        end else if (i_cmd_dir == XFER_DIR_WR) begin
          state_s = XFER_WRITE;
        end else begin
          state_s = XFER_READ;
        end
      end
      XFER_WRITE: begin
        o_wr_ready       = 1'b1;
        o_host_mem_wr_en = i_wr_valid;
        wr_hs_s          = i_wr_valid;
        if (i_wr_valid && last_s) begin
          state_s = XFER_DONE;
        end else begin
          state_s = XFER_WRITE;
        end
      end
      XFER_READ: begin
        o_host_mem_rd_en = 1'b1;
        load_s           = (!o_rd_valid || i_rd_ready) && rem_nz_s;
        if (rd_hs_s && o_rd_last) begin
          state_s = XFER_DONE;
        end else begin
          state_s = XFER_READ;
        end
      end
      XFER_DONE: begin
        state_s = XFER_IDLE;
      end
      default: begin
        state_s = XFER_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_r <= XFER_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Address and remaining-count tracking; rem stops at zero so it cannot wrap.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      addr_r <= {ADDR_W{1'b0}};
      rem_r  <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      addr_r <= i_cmd_base;
      rem_r  <= i_cmd_len;
    end else if ((wr_hs_s || load_s) && rem_nz_s) begin
      addr_r <= addr_r + ADDR_W'(1);
      rem_r  <= rem_r - LEN_W'(1);
    end
  end

  // Completion pulse, registered off the DONE state.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == XFER_DONE);
    end
  end

  xfer_rd_outreg #(
    .W(`WORD_LEN)
  ) u_rd_outreg (
    .clk      (i_sys_clk),
    .rst_n    (i_sys_rst),
    .load     (load_s),
    .last_in  (last_s),
    .din      (i_host_dout),
    .rd_ready (i_rd_ready),
    .rd_data  (o_rd_data),
    .rd_valid (o_rd_valid),
    .rd_last  (o_rd_last)
  );

`ifdef HOST_MEM_CHKSUM_EN
  logic [`WORD_LEN-1:0] chksum_r;

  // Running sum of words handshaked on whichever stream is active.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      chksum_r <= {`WORD_LEN{1'b0}};
    end else if (accept_s) begin
      chksum_r <= {`WORD_LEN{1'b0}};
    end else if (wr_hs_s) begin
      chksum_r <= chksum_r + i_wr_data;
    end else if (rd_hs_s) begin
      chksum_r <= chksum_r + o_rd_data;
    end
  end

  assign o_chksum = chksum_r;
`endif

endmodule

// File: tb/tb_host_mem_xfer_ctrl.sv
// Scoreboard bench for host_mem_xfer_ctrl: expected port-B writes and read words are queued
// as stimulus is driven and popped as the DUT produces them.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_host_mem_xfer_ctrl;
  import host_mem_xfer_ctrl_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W      = `WORD_LEN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_cmd_valid, o_cmd_ready, i_cmd_dir;
  logic [ADDR_W-1:0] i_cmd_base;
  logic [LEN_W-1:0]  i_cmd_len;
  logic [W-1:0]      i_wr_data, o_rd_data, o_host_din, i_host_dout;
  logic              i_wr_valid, o_wr_ready, o_rd_valid, i_rd_ready, o_rd_last;
  logic              o_host_mem_wr_en, o_host_mem_rd_en, o_busy, o_done;
  logic [ADDR_W-1:0] o_host_addr;
`ifdef HOST_MEM_CHKSUM_EN
  logic [W-1:0]      o_chksum;
`endif

  int total = 0;
  int bad   = 0;
  int wr_evt = 0;

  logic [W-1:0] mem   [DEPTH];
  logic [W-1:0] model [DEPTH];

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [W-1:0] data; } wr_exp_t;
  typedef struct packed { logic [W-1:0] data; logic last; } rd_exp_t;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];

  always #5 clk = ~clk;

  host_mem_xfer_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_dir(i_cmd_dir),
    .i_cmd_base(i_cmd_base), .i_cmd_len(i_cmd_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_last(o_rd_last),
    .o_host_mem_wr_en(o_host_mem_wr_en), .o_host_mem_rd_en(o_host_mem_rd_en),
    .o_host_addr(o_host_addr), .o_host_din(o_host_din), .i_host_dout(i_host_dout),
    .o_busy(o_busy), .o_done(o_done)
`ifdef HOST_MEM_CHKSUM_EN
    , .o_chksum(o_chksum)
`endif
  );

  // Port-B memory with zero read latency, plus a count of write strobes seen at clock edges.
  always @(posedge clk) begin
    if (o_host_mem_wr_en) begin
      mem[o_host_addr] <= o_host_din;
      wr_evt <= wr_evt + 1;
    end
  end
  assign i_host_dout = mem[o_host_addr];

  // Present a command from the post-edge phase; returns one phase after the accepting edge.
  task automatic send_cmd(input logic dir, input int base, input int len, output bit ok);
    i_cmd_valid = 1'b1;
    i_cmd_dir   = dir;
    i_cmd_base  = base[ADDR_W-1:0];
    i_cmd_len   = len[LEN_W-1:0];
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (o_cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_dir = 1'b0; i_cmd_base = '0; i_cmd_len = '0;
    i_wr_data = '0; i_wr_valid = 1'b0; i_rd_ready = 1'b0;
    #12;
    total += 5;
    if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", o_cmd_ready); end
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", o_busy, o_done); end
    if (o_rd_valid !== 1'b0 || o_rd_last !== 1'b0) begin bad++; $display("FAIL reset_rd_flags got=%b%b exp=00", o_rd_valid, o_rd_last); end
    if (o_rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", o_rd_data); end
    if (o_host_mem_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", o_host_mem_wr_en); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_write(input int base, input int len, input logic [W-1:0] first, input logic [W-1:0] step);
    int sent = 0, done_cnt = 0, post = 0, a;
    bit ok;
    wr_exp_t e;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % DEPTH;
      e.addr = a[ADDR_W-1:0];
      e.data = first + step * W'(i);
      wr_q.push_back(e);
      model[a] = e.data;
    end
    send_cmd(XFER_DIR_WR, base, len, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wr_cmd_accept timeout base=%0d len=%0d", base, len); end
    i_wr_valid = 1'b1;
    i_wr_data  = first;
    for (int c = 0; c < len + 10; c++) begin
      @(negedge clk);
      if (o_host_mem_wr_en) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++; $display("FAIL extra_write addr=%0d data=%h exp=none", o_host_addr, o_host_din);
        end else begin
          e = wr_q.pop_front();
          if (o_host_addr !== e.addr || o_host_din !== e.data) begin
            bad++; $display("FAIL write_word got=%0d/%h exp=%0d/%h", o_host_addr, o_host_din, e.addr, e.data);
          end
        end
      end
      if (o_done) done_cnt++;
      if (o_wr_ready && i_wr_valid) sent++;
      @(posedge clk); #1;
      i_wr_data = first + step * W'(sent);
      if (done_cnt > 0) post++;
      if (post >= 2) break;
    end
    i_wr_valid = 1'b0;
    total += 4;
    if (wr_q.size() != 0) begin bad++; $display("FAIL write_missing got=%0d left exp=0", wr_q.size()); wr_q.delete(); end
    if (done_cnt != 1) begin bad++; $display("FAIL write_done_pulses got=%0d exp=1", done_cnt); end
    if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL write_cmd_ready got=%b exp=1", o_cmd_ready); end
    a = (base + len) % DEPTH;
    if (o_host_addr !== a[ADDR_W-1:0]) begin bad++; $display("FAIL write_end_addr got=%0d exp=%0d", o_host_addr, a); end
  endtask

  task automatic run_read(input int base, input int len, input logic [15:0] pat, output int first_hs, output int last_hs);
    int done_cnt = 0, post = 0, cyc = 0, a;
    bit ok, prev_stall = 1'b0;
    logic [W-1:0] held_d;
    logic held_l;
    rd_exp_t e;
    first_hs = -1; last_hs = -1;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % DEPTH;
      e.data = model[a];
      e.last = (i == len - 1);
      rd_q.push_back(e);
    end
    send_cmd(XFER_DIR_RD, base, len, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rd_cmd_accept timeout base=%0d len=%0d", base, len); end
    i_rd_ready = pat[0];
    for (int c = 0; c < len + 30; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== held_d || o_rd_last !== held_l) begin
          bad++; $display("FAIL read_hold got=%b/%h/%b exp=1/%h/%b", o_rd_valid, o_rd_data, o_rd_last, held_d, held_l);
        end
      end
      if (o_rd_valid && i_rd_ready) begin
        total++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (rd_q.size() == 0) begin
          bad++; $display("FAIL extra_read got=%h exp=none", o_rd_data);
        end else begin
          e = rd_q.pop_front();
          if (o_rd_data !== e.data || o_rd_last !== e.last) begin
            bad++; $display("FAIL read_word got=%h/%b exp=%h/%b", o_rd_data, o_rd_last, e.data, e.last);
          end
        end
      end
      prev_stall = o_rd_valid && !i_rd_ready;
      held_d = o_rd_data;
      held_l = o_rd_last;
      if (o_done) done_cnt++;
      @(posedge clk); #1;
      cyc++;
      i_rd_ready = (cyc < 16) ? pat[cyc] : 1'b1;
      if (done_cnt > 0) post++;
      if (post >= 2) break;
    end
    i_rd_ready = 1'b0;
    total += 4;
    if (rd_q.size() != 0) begin bad++; $display("FAIL read_missing got=%0d left exp=0", rd_q.size()); rd_q.delete(); end
    if (done_cnt != 1) begin bad++; $display("FAIL read_done_pulses got=%0d exp=1", done_cnt); end
    if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL read_valid_after got=%b exp=0", o_rd_valid); end
    a = (base + len) % DEPTH;
    if (o_host_addr !== a[ADDR_W-1:0]) begin bad++; $display("FAIL read_end_addr got=%0d exp=%0d", o_host_addr, a); end
  endtask

  task automatic test_write();
    run_write(0, 4, 32'h11, 32'h11);
`ifdef HOST_MEM_CHKSUM_EN
    total++;
    if (o_chksum !== 32'hAA) begin bad++; $display("FAIL chksum got=%h exp=aa", o_chksum); end
`endif
  endtask

  task automatic test_read_stream();
    int f, l;
    run_read(0, 4, 16'hFFFF, f, l);
    total += 2;
    if (f != 1) begin bad++; $display("FAIL read_latency got=%0d exp=1", f); end
    if (l - f != 3) begin bad++; $display("FAIL read_throughput got=%0d exp=3", l - f); end
  endtask

  task automatic test_read_backpressure();
    int f, l;
    run_read(1, 3, 16'hFFF9, f, l);
  endtask

  task automatic test_write_wrap();
    int f, l;
    run_write(1022, 4, 32'hA000_0001, 32'h0000_0101);
    run_read(1020, 6, 16'hFFFF, f, l);
  endtask

  task automatic test_len_zero();
    bit ok;
    bit strobe = 1'b0;
    int done_at = -1, done_cnt = 0;
    i_wr_valid = 1'b1;
    i_rd_ready = 1'b1;
    send_cmd(XFER_DIR_WR, 7, 0, ok);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (o_host_mem_wr_en || o_host_mem_rd_en) strobe = 1'b1;
      if (o_done) begin done_cnt++; if (done_at < 0) done_at = c; end
      @(posedge clk); #1;
    end
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    total += 4;
    if (!ok) begin bad++; $display("FAIL len0_accept timeout"); end
    if (strobe) begin bad++; $display("FAIL len0_strobe got=1 exp=0"); end
    if (done_at != 2) begin bad++; $display("FAIL len0_done_cycle got=%0d exp=2", done_at); end
    if (done_cnt != 1) begin bad++; $display("FAIL len0_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_full_len();
    run_write(5, 1024, 32'h0BAD_0000, 32'h1);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int base_evt;
    bit stray = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_data  = 32'h5555_0000;
    send_cmd(XFER_DIR_WR, 100, 6, ok);
    base_evt = wr_evt;
    @(posedge clk); #1; i_wr_data = 32'h5555_0001;
    @(posedge clk); #1; i_wr_data = 32'h5555_0002;
    #2; rst_n = 1'b0; #1;
    total += 5;
    if (!ok) begin bad++; $display("FAIL rst_accept timeout"); end
    if (o_host_mem_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", o_host_mem_wr_en); end
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b%b exp=10", o_cmd_ready, o_busy); end
    if (o_done !== 1'b0 || o_rd_valid !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", o_done, o_rd_valid); end
    if (wr_evt - base_evt != 2) begin bad++; $display("FAIL rst_writes_before got=%0d exp=2", wr_evt - base_evt); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_host_mem_wr_en || o_busy) stray = 1'b1;
    end
    @(posedge clk); #1;
    i_wr_valid = 1'b0;
    total += 2;
    if (stray) begin bad++; $display("FAIL rst_after_activity got=1 exp=0"); end
    if (wr_evt - base_evt != 2) begin bad++; $display("FAIL rst_writes_total got=%0d exp=2", wr_evt - base_evt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stream();
    test_read_backpressure();
    test_write_wrap();
    test_len_zero();
    test_full_len();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_mem_xfer_ctrl.md
Name: host_mem_xfer_ctrl

Overview:
- Host-side transfer engine that drives the host port (port B) of the data memory in the MIPS kernel.
- Accepts a command of {direction, base address, length}.
  - Write direction: streams words from the host into data memory.
  - Read direction: streams words out of data memory to the host.
- Valid/ready handshakes on both host streams; generates host-port write enable, read enable, address and data-in each cycle.
- Runs concurrently with kernel port-A accesses. Write-collision arbitration is out of scope.

Parameters:
- ADDR_W, 10, host-port address width; memory depth is 2**ADDR_W words.
- LEN_W, 11, command length width; must satisfy LEN_W = ADDR_W+1 so one command can cover the full memory.

Ports:
- i_sys_clk  in  1  system clock; all logic is on the rising edge.
- i_sys_rst  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when high together with i_cmd_valid; high only in IDLE.
- i_cmd_dir  in  1  0 = host→memory write, 1 = memory→host read.
- i_cmd_base  in  ADDR_W  first word address.
- i_cmd_len  in  LEN_W  word count, 0..2**ADDR_W.
- i_wr_data  in  `WORD_LEN  host write word.
- i_wr_valid  in  1  host write word valid.
- o_wr_ready  out  1  engine can take a write word.
- o_rd_data  out  `WORD_LEN  read word to host.
- o_rd_valid  out  1  read word valid.
- i_rd_ready  in  1  host accepts read word.
- o_rd_last  out  1  marks the final word of a read command.
- o_host_mem_wr_en  out  1  memory port-B write enable.
- o_host_mem_rd_en  out  1  memory port-B read strobe.
- o_host_addr  out  ADDR_W  memory port-B address.
- o_host_din  out  `WORD_LEN  memory port-B write data.
- i_host_dout  in  `WORD_LEN  memory port-B read data; combinational (read latency 0).
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (i_sys_rst low, asynchronous):
  - FSM goes to IDLE.
  - Address counter and remaining-count register cleared.
  - o_rd_valid, o_rd_last, o_done, o_busy and o_host_mem_wr_en are 0; o_rd_data is 0.
  - o_cmd_ready is 1 after reset.
  - Reset mid-transfer aborts the command. No further memory write occurs after reset assertion.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - On i_cmd_valid && o_cmd_ready, latch the base into addr and the length into rem.
  - If len == 0, go to DONE.
  - Otherwise go to WRITE (dir 0) or READ (dir 1).
- WRITE:
  - o_wr_ready = 1 (combinational in this state).
  - o_host_mem_wr_en = i_wr_valid; o_host_din = i_wr_data; o_host_addr = addr.
  - On each handshake: addr += 1, rem -= 1. When rem reaches 0 after a handshake, go to DONE.
  - Throughput: 1 word/cycle, 0-cycle latency to the memory write.
- READ:
  - o_host_addr = addr; o_host_mem_rd_en = 1.
  - Output register load condition: (!o_rd_valid || i_rd_ready) && rem != 0.
  - On load: o_rd_data <= i_host_dout, o_rd_valid <= 1, o_rd_last <= (rem == 1), addr += 1, rem -= 1.
  - If the load condition fails and the held word is consumed, o_rd_valid <= 0.
  - Go to DONE once the word with o_rd_last is consumed.
  - Latency: address presented → o_rd_data valid = 1 cycle. Full throughput under continuous i_rd_ready.
  - Backpressure: o_rd_data and o_rd_last hold stable while o_rd_valid && !i_rd_ready.
- DONE: o_done = 1 for one cycle, then IDLE.
- Address arithmetic is modulo 2**ADDR_W. Example: base 1020, len 8 → addresses 1020..1023, then 0..3.
- rem is LEN_W bits and never underflows.
- Commands arriving while busy wait for o_cmd_ready; they are never dropped or merged.
- o_host_mem_wr_en is never asserted outside WRITE.

Optional Feature:
- Macro HOST_MEM_CHKSUM_EN.
- Defined:
  - Adds output o_chksum [`WORD_LEN-1:0].
  - Value is a running modulo-2**`WORD_LEN sum of every word handshaked on the active stream.
  - Cleared to 0 on command accept and on reset; holds its value after DONE until the next accept.
- Not defined: the port and the adder do not exist.

Decomposition:
- Shared package / `defines.v`: FSM state encodings (XFER_IDLE, XFER_WRITE, XFER_READ, XFER_DONE) and the direction constants XFER_DIR_WR = 0, XFER_DIR_RD = 1. `WORD_LEN` comes from the existing defines.
- Sub-module xfer_rd_outreg: the one-entry read output register with valid/ready hold logic. Write path and FSM stay in the top module.

Test Plan:
- Write base 0, len 4, data 0x11,0x22,0x33,0x44, i_wr_valid constant → o_host_mem_wr_en high for 4 cycles at addresses 0..3, o_done pulses once, o_cmd_ready returns high.
- Read base 0, len 4 against a memory model holding the above, i_rd_ready = 1 → o_rd_data sequence 0x11,0x22,0x33,0x44, o_rd_last only on 0x44, 4 consecutive valid cycles.
- Read len 3 with i_rd_ready toggling 1,0,0,1,1 → each word held stable while stalled, no duplicates or losses, no extra address advances.
- Write base 1022, len 4 → addresses 1022, 1023, 0, 1; rem ends at 0; no write beyond the 4th word.
- Command len 0 → no memory strobe, o_done pulse exactly 2 cycles after accept; len 1024 base 5 → 1024 writes, final address 4.
- Assert reset after 2 of 6 write words → o_host_mem_wr_en drops immediately, FSM in IDLE, o_cmd_ready = 1. With HOST_MEM_CHKSUM_EN, the len-4 write above gives o_chksum = 0xAA.
